// File: rtl/controlador_de_status_pkg.sv
// Shared definitions for the status controller: the {A,B} state encoding and the
// helper that sizes the phase countdown.
package controlador_de_status_pkg;

    // The decoder downstream reads the state register bits directly as {A,B}.
    typedef enum logic [1:0] {
        DESLIGADO  = 2'b00,
        PREPARACAO = 2'b10,
        ATAQUE     = 2'b11
    } estado_t;

    function automatic int largura_contagem(input int tempo_prep, input int tempo_ataque);
        int maior;
        maior = (tempo_prep > tempo_ataque) ? tempo_prep : tempo_ataque;
        return $clog2(maior + 1);
    endfunction

endpackage

// File: rtl/controlador_de_status_sincronizador.sv
// Two-flop synchronizer for an asynchronous operator input, with a registered copy of the
// synchronized level so a one-cycle rising-edge pulse can be derived from it.
module sincronizador (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic sinc_o,
    output logic borda_o
);

    logic meta_q;
    logic sinc_q;
    logic anterior_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q     <= 1'b0;
            sinc_q     <= 1'b0;
            anterior_q <= 1'b0;
        end else begin
            meta_q     <= d_i;
            sinc_q     <= meta_q;
            anterior_q <= sinc_q;
        end
    end

    assign sinc_o  = sinc_q;
    assign borda_o = sinc_q & ~anterior_q;

endmodule

// File: rtl/controlador_de_status.sv
// Status controller: sequences DESLIGADO -> PREPARACAO (timed arming) -> ATAQUE (timed burst)
// and drives the registered 2-bit status code {A,B} for the downstream decoder.
module controlador_de_status
    import controlador_de_status_pkg::*;
#(
    parameter  int TEMPO_PREP      = 8,
    parameter  int TEMPO_ATAQUE    = 4,
    parameter  int LARGURA_ATAQUES = 4,
    localparam int CW              = largura_contagem(TEMPO_PREP, TEMPO_ATAQUE)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       liga,
    input  logic                       disparo,
    input  logic                       aborta,
    output logic                       A,
    output logic                       B,
    output logic                       pronto,
    output logic [CW-1:0]              contagem,
    output logic [LARGURA_ATAQUES-1:0] ataques
);

    localparam logic [CW-1:0] PREP_INI   = CW'(TEMPO_PREP);
    localparam logic [CW-1:0] ATAQUE_INI = CW'(TEMPO_ATAQUE - 1);

    logic liga_s, aborta_s, disparo_s, disparo_ev;
    logic liga_borda, aborta_borda;
    logic unused_bordas;

    estado_t                    estado_q,   estado_d;
    logic [CW-1:0]              contagem_q, contagem_d;
    logic [LARGURA_ATAQUES-1:0] ataques_q,  ataques_d;

    sincronizador u_sinc_liga (
        .clk     (clk),
        .rst_n   (rst_n),
        .d_i     (liga),
        .sinc_o  (liga_s),
        .borda_o (liga_borda)
    );

    sincronizador u_sinc_aborta (
        .clk     (clk),
        .rst_n   (rst_n),
        .d_i     (aborta),
        .sinc_o  (aborta_s),
        .borda_o (aborta_borda)
    );

    sincronizador u_sinc_disparo (
        .clk     (clk),
        .rst_n   (rst_n),
        .d_i     (disparo),
        .sinc_o  (disparo_s),
        .borda_o (disparo_ev)
    );

    // liga and aborta act on level; only the fire button needs its edge.
    assign unused_bordas = liga_borda ^ aborta_borda ^ disparo_s;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado_q   <= DESLIGADO;
            contagem_q <= '0;
            ataques_q  <= '0;
        end else begin
            estado_q   <= estado_d;
            contagem_q <= contagem_d;
            ataques_q  <= ataques_d;
        end
    end

    // Priority: power switch off, then abort, then timer / fire event.
    always_comb begin
        estado_d   = estado_q;
        contagem_d = contagem_q;
        ataques_d  = ataques_q;
        case (estado_q)
            DESLIGADO: begin
                if (liga_s) begin
                    estado_d   = PREPARACAO;
                    contagem_d = PREP_INI;
                end else begin
                    contagem_d = '0;
                end
            end
            PREPARACAO: begin
                if (!liga_s) begin
                    estado_d   = DESLIGADO;
                    contagem_d = '0;
                end else if (contagem_q != '0) begin
                    contagem_d = contagem_q - CW'(1);
                end else if (disparo_ev) begin
                    estado_d   = ATAQUE;
                    contagem_d = ATAQUE_INI;
                end
            end
            ATAQUE: begin
                if (!liga_s) begin
                    estado_d   = DESLIGADO;
                    contagem_d = '0;
                end else if (aborta_s) begin
                    estado_d   = PREPARACAO;
                    contagem_d = PREP_INI;
                end else if (contagem_q == '0) begin
                    estado_d   = PREPARACAO;
                    contagem_d = PREP_INI;
                    ataques_d  = ataques_q + LARGURA_ATAQUES'(1);
                end else begin
                    contagem_d = contagem_q - CW'(1);
                end
            end
            default: begin
                estado_d   = DESLIGADO;
                contagem_d = '0;
            end
        endcase
    end

    assign {A, B}   = estado_q;
    assign pronto   = (estado_q == PREPARACAO) && (contagem_q == '0);
    assign contagem = contagem_q;
    assign ataques  = ataques_q;

endmodule

// File: tb/tb_controlador_de_status.sv
// Directed bench for controlador_de_status with TEMPO_PREP=8, TEMPO_ATAQUE=4, LARGURA_ATAQUES=4.
module tb_controlador_de_status;

    logic       clk;
    logic       rst_n;
    logic       liga;
    logic       disparo;
    logic       aborta;
    logic       A;
    logic       B;
    logic       pronto;
    logic [3:0] contagem;
    logic [3:0] ataques;

    int checks = 0;
    int errors = 0;

    controlador_de_status #(
        .TEMPO_PREP      (8),
        .TEMPO_ATAQUE    (4),
        .LARGURA_ATAQUES (4)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .liga     (liga),
        .disparo  (disparo),
        .aborta   (aborta),
        .A        (A),
        .B        (B),
        .pronto   (pronto),
        .contagem (contagem),
        .ataques  (ataques)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance n rising edges and settle 1 time unit past the last one.
    task automatic passo(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic verifica(input string tag, input logic [7:0] obs, input logic [7:0] esp);
        checks++;
        assert (obs === esp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, esp);
        end
    endtask

    // Checks status code, countdown, armed flag and attack count together.
    task automatic verifica_tudo(input string tag, input logic [1:0] ab, input logic [3:0] cnt,
                                 input logic pr, input logic [3:0] atq);
        verifica({tag, ".AB"},       {6'd0, A, B},   {6'd0, ab});
        verifica({tag, ".contagem"}, {4'd0, contagem}, {4'd0, cnt});
        verifica({tag, ".pronto"},   {7'd0, pronto}, {7'd0, pr});
        verifica({tag, ".ataques"},  {4'd0, ataques}, {4'd0, atq});
    endtask

    initial begin
        rst_n   = 1'b0;
        liga    = 1'b0;
        disparo = 1'b0;
        aborta  = 1'b0;
        passo(2);
        verifica_tudo("reset", 2'b00, 4'd0, 1'b0, 4'd0);
        rst_n = 1'b1;
        passo(2);
        verifica_tudo("idle", 2'b00, 4'd0, 1'b0, 4'd0);

        // Power on: three edges to PREPARACAO, then eight cycles of arming.
        liga = 1'b1;
        passo(2);
        verifica_tudo("liga_2", 2'b00, 4'd0, 1'b0, 4'd0);
        passo(1);
        verifica_tudo("liga_3", 2'b10, 4'd8, 1'b0, 4'd0);

        // Early fire press is dropped, not queued.
        disparo = 1'b1;
        passo(3);
        verifica_tudo("cedo", 2'b10, 4'd5, 1'b0, 4'd0);
        disparo = 1'b0;
        passo(1);
        verifica_tudo("cedo_sol", 2'b10, 4'd4, 1'b0, 4'd0);
        passo(3);
        verifica_tudo("prep_7", 2'b10, 4'd1, 1'b0, 4'd0);
        passo(1);
        verifica_tudo("pronto", 2'b10, 4'd0, 1'b1, 4'd0);
        passo(2);
        verifica_tudo("pronto_esp", 2'b10, 4'd0, 1'b1, 4'd0);

        // Fire when armed: ATAQUE for exactly four cycles; disparo stays held afterwards.
        disparo = 1'b1;
        passo(2);
        verifica_tudo("disp_2", 2'b10, 4'd0, 1'b1, 4'd0);
        passo(1);
        verifica_tudo("atq_c1", 2'b11, 4'd3, 1'b0, 4'd0);
        passo(3);
        verifica_tudo("atq_c4", 2'b11, 4'd0, 1'b0, 4'd0);
        passo(1);
        verifica_tudo("atq_fim", 2'b10, 4'd8, 1'b0, 4'd1);

        // Held button through two prep periods fires only once.
        passo(8);
        verifica_tudo("seg_pronto", 2'b10, 4'd0, 1'b1, 4'd1);
        passo(9);
        verifica_tudo("seg_mant", 2'b10, 4'd0, 1'b1, 4'd1);
        disparo = 1'b0;
        passo(4);

        // Abort seen by the FSM during the second ATAQUE cycle.
        disparo = 1'b1;
        passo(2);
        aborta = 1'b1;
        passo(1);
        verifica_tudo("abt_c1", 2'b11, 4'd3, 1'b0, 4'd1);
        aborta = 1'b0;
        passo(1);
        verifica_tudo("abt_c2", 2'b11, 4'd2, 1'b0, 4'd1);
        passo(1);
        verifica_tudo("abt_prep", 2'b10, 4'd8, 1'b0, 4'd1);
        disparo = 1'b0;
        passo(8);
        verifica_tudo("abt_pronto", 2'b10, 4'd0, 1'b1, 4'd1);

        // Power off during ATAQUE.
        disparo = 1'b1;
        passo(3);
        verifica_tudo("off_atq_c1", 2'b11, 4'd3, 1'b0, 4'd1);
        liga = 1'b0;
        passo(2);
        verifica_tudo("off_atq_2", 2'b11, 4'd1, 1'b0, 4'd1);
        passo(1);
        verifica_tudo("off_atq", 2'b00, 4'd0, 1'b0, 4'd1);
        disparo = 1'b0;

        // Power off during PREPARACAO.
        liga = 1'b1;
        passo(3);
        verifica_tudo("off_prep_in", 2'b10, 4'd8, 1'b0, 4'd1);
        liga = 1'b0;
        passo(2);
        verifica_tudo("off_prep_2", 2'b10, 4'd6, 1'b0, 4'd1);
        passo(1);
        verifica_tudo("off_prep", 2'b00, 4'd0, 1'b0, 4'd1);

        // Fifteen more completed attacks wrap the 4-bit counter to zero.
        liga = 1'b1;
        passo(3);
        for (int i = 0; i < 15; i++) begin
            passo(8);
            disparo = 1'b1;
            passo(3);
            disparo = 1'b0;
            passo(4);
            verifica("wrap_ataques", {4'd0, ataques}, 8'((i + 2) % 16));
        end
        verifica_tudo("wrap", 2'b10, 4'd8, 1'b0, 4'd0);

        // Asynchronous reset in the middle of ATAQUE.
        passo(8);
        disparo = 1'b1;
        passo(3);
        verifica_tudo("rst_atq", 2'b11, 4'd3, 1'b0, 4'd0);
        passo(1);
        rst_n = 1'b0;
        #1;
        verifica_tudo("rst_imed", 2'b00, 4'd0, 1'b0, 4'd0);
        disparo = 1'b0;
        passo(2);
        verifica_tudo("rst_mant", 2'b00, 4'd0, 1'b0, 4'd0);
        rst_n = 1'b1;
        passo(3);
        verifica_tudo("rst_volta", 2'b10, 4'd8, 1'b0, 4'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
